id_stage: RTL and testbench

- Decode stage of the 5-stage RV32E pipeline; sits between IF and EX, directly upstream of the 16-entry register file.
- Drives regfile read addresses and takes the raw read data back.
- Resolves operand hazards by bypassing from EX/MEM/WB (the register file has no internal write bypass) or by stalling, then registers the decoded bundle into the ID/EX pipeline register.

---
 rtl/id_pkg.sv | 41 ++++
 rtl/id_imm_gen.sv | 25 ++
 rtl/id_stage.sv | 153 +++++++++++++++
 tb/tb_id_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode-stage types: opcode constants, immediate formats and the ID/EX bundle.
package id_pkg;

  localparam int XLEN      = 32;
  localparam int NREG_BITS = 4;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [XLEN-1:0]    imm;
    logic [NREG_BITS:0] rd;
    logic               wen;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               illegal;
  } idex_t;

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: purely combinational, sign-extends I/S/B/J, left-aligns U.
module id_imm_gen
  import id_pkg::*;
(
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32E decode stage: combinational regfile addressing and operand bypass, 1-cycle ID/EX register.
// Stalls IF on load-use (or any EX/MEM hazard when ID_MEM_FWD_EN is undefined); pipeline_en=0 freezes state.
module id_stage
  import id_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipeline_en,
  input  logic                 if_valid,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [31:0]          if_instr,
  output logic                 stall,
  input  logic                 flush,
  output logic [NREG_BITS:0]   rs1,
  output logic [NREG_BITS:0]   rs2,
  input  logic [XLEN-1:0]      reg1,
  input  logic [XLEN-1:0]      reg2,
  input  logic [NREG_BITS:0]   ex_rd,
  input  logic                 ex_wen,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [NREG_BITS:0]   mem_rd,
  input  logic                 mem_wen,
  input  logic [XLEN-1:0]      mem_result,
  input  logic [NREG_BITS:0]   wb_rd,
  input  logic                 wb_wen,
  input  logic [XLEN-1:0]      wb_wdata,
  output logic                 idex_valid,
  output logic [XLEN-1:0]      idex_pc,
  output logic [XLEN-1:0]      idex_op1,
  output logic [XLEN-1:0]      idex_op2,
  output logic [XLEN-1:0]      idex_imm,
  output logic [NREG_BITS:0]   idex_rd,
  output logic                 idex_wen,
  output logic [6:0]           idex_opcode,
  output logic [2:0]           idex_funct3,
  output logic                 idex_funct7b5,
  output logic                 idex_illegal
);

  logic [6:0]         opcode;
  logic [NREG_BITS:0] rd;
  logic               use1, use2, use_rd, legal_op, illegal;
  imm_type_e          imm_type;
  logic [XLEN-1:0]    imm;
  logic [XLEN-1:0]    op1, op2;
  logic               ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  idex_t              dec, idex_q;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  always_comb begin
    legal_op = 1'b1;
    use1     = 1'b0;
    use2     = 1'b0;
    use_rd   = 1'b0;
    imm_type = IMM_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin use_rd = 1'b1; imm_type = IMM_U; end
      OPC_JAL:            begin use_rd = 1'b1; imm_type = IMM_J; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        use1 = 1'b1; use_rd = 1'b1; imm_type = IMM_I;
      end
      OPC_BRANCH:   begin use1 = 1'b1; use2 = 1'b1; imm_type = IMM_B; end
      OPC_STORE:    begin use1 = 1'b1; use2 = 1'b1; imm_type = IMM_S; end
      OPC_OP:       begin use1 = 1'b1; use2 = 1'b1; use_rd = 1'b1; end
      OPC_MISC_MEM: legal_op = 1'b1;
      default:      legal_op = 1'b0;
    endcase
  end

  // x16..x31 do not exist in RV32E
  assign illegal = !legal_op || (use1 && rs1[NREG_BITS]) || (use2 && rs2[NREG_BITS])
                 || (use_rd && rd[NREG_BITS]);

  assign ex_m1  = use1 && (rs1 != '0) && ex_wen  && (ex_rd  == rs1);
  assign ex_m2  = use2 && (rs2 != '0) && ex_wen  && (ex_rd  == rs2);
  assign mem_m1 = use1 && (rs1 != '0) && mem_wen && (mem_rd == rs1);
  assign mem_m2 = use2 && (rs2 != '0) && mem_wen && (mem_rd == rs2);
  assign wb_m1  = use1 && (rs1 != '0) && wb_wen  && (wb_rd  == rs1);
  assign wb_m2  = use2 && (rs2 != '0) && wb_wen  && (wb_rd  == rs2);

`ifdef ID_MEM_FWD_EN
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use1 && rs1 != '0) op1 = ex_m1 ? ex_result : mem_m1 ? mem_result : wb_m1 ? wb_wdata : reg1;
    if (use2 && rs2 != '0) op2 = ex_m2 ? ex_result : mem_m2 ? mem_result : wb_m2 ? wb_wdata : reg2;
  end

  assign stall = if_valid && ex_is_load && (ex_m1 || ex_m2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_result, ex_is_load};

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (use1 && rs1 != '0) op1 = wb_m1 ? wb_wdata : reg1;
    if (use2 && rs2 != '0) op2 = wb_m2 ? wb_wdata : reg2;
  end

  // Without EX/MEM paths the consumer waits until the producer sits in WB
  assign stall = if_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

  id_imm_gen u_imm_gen (
    .instr    (if_instr),
    .imm_type (imm_type),
    .imm      (imm)
  );

  always_comb begin
    dec          = '0;
    dec.valid    = if_valid;
    dec.pc       = if_pc;
    dec.op1      = op1;
    dec.op2      = op2;
    dec.imm      = imm;
    dec.rd       = rd;
    // an invalid slot must never look like a forwarding producer downstream
    dec.wen      = if_valid && use_rd && (rd != '0) && !illegal;
    dec.opcode   = opcode;
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    dec.illegal  = illegal;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (pipeline_en) begin
      if (flush || stall) idex_q <= '0;
      else                idex_q <= dec;
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_pc       = idex_q.pc;
  assign idex_op1      = idex_q.op1;
  assign idex_op2      = idex_q.op2;
  assign idex_imm      = idex_q.imm;
  assign idex_rd       = idex_q.rd;
  assign idex_wen      = idex_q.wen;
  assign idex_opcode   = idex_q.opcode;
  assign idex_funct3   = idex_q.funct3;
  assign idex_funct7b5 = idex_q.funct7b5;
  assign idex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pipeline_en, if_valid, flush;
  logic [31:0] if_pc, if_instr, reg1, reg2, ex_result, mem_result, wb_wdata;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_wen, ex_is_load, mem_wen, wb_wen;

  logic        stall, idex_valid, idex_wen, idex_funct7b5, idex_illegal;
  logic [4:0]  rs1, rs2, idex_rd;
  logic [31:0] idex_pc, idex_op1, idex_op2, idex_imm;
  logic [6:0]  idex_opcode;
  logic [2:0]  idex_funct3;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .pipeline_en(pipeline_en),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
    .reg1(reg1), .reg2(reg2),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_wdata(wb_wdata),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_op1(idex_op1), .idex_op2(idex_op2),
    .idex_imm(idex_imm), .idex_rd(idex_rd), .idex_wen(idex_wen), .idex_opcode(idex_opcode),
    .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5), .idex_illegal(idex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } exp_t;

  exp_t exp_q = '0;
  int   total = 0;
  int   bad   = 0;
  logic last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // kind: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
  function automatic void classify(input logic [6:0] opc, output logic legal, output logic u1,
                                   output logic u2, output logic wr, output int kind);
    legal = 1; u1 = 0; u2 = 0; wr = 0; kind = 0;
    case (opc)
      7'h37, 7'h17: begin wr = 1; kind = 4; end
      7'h6F:        begin wr = 1; kind = 5; end
      7'h67, 7'h03, 7'h13: begin u1 = 1; wr = 1; kind = 1; end
      7'h63:        begin u1 = 1; u2 = 1; kind = 3; end
      7'h23:        begin u1 = 1; u2 = 1; kind = 2; end
      7'h33:        begin u1 = 1; u2 = 1; wr = 1; end
      7'h0F:        legal = 1;
      default:      legal = 0;
    endcase
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] ins, input int kind);
    case (kind)
      1: return ins[30:20] - (ins[31] ? 32'd2048 : 32'd0);
      2: return ins[30:25] * 32'd32 + ins[11:7] - (ins[31] ? 32'd2048 : 32'd0);
      3: return ins[7] * 32'd2048 + ins[30:25] * 32'd32 + ins[11:8] * 32'd2
              - (ins[31] ? 32'd4096 : 32'd0);
      4: return ins & 32'hFFFFF000;
      5: return ins[19:12] * 32'd4096 + ins[20] * 32'd2048 + ins[30:21] * 32'd2
              - (ins[31] ? 32'h0010_0000 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit hit(input logic used, input logic [4:0] rs, input logic wen,
                             input logic [4:0] rd);
    return used && rs != 0 && wen && rd == rs;
  endfunction

  function automatic logic [31:0] operand(input logic used, input logic [4:0] rs,
                                          input logic [31:0] rf);
    if (!used || rs == 0) return 32'd0;
`ifdef ID_MEM_FWD_EN
    if (ex_wen && ex_rd == rs) return ex_result;
    if (mem_wen && mem_rd == rs) return mem_result;
`endif
    if (wb_wen && wb_rd == rs) return wb_wdata;
    return rf;
  endfunction

  task automatic model(output logic st, output exp_t nx);
    logic legal, u1, u2, wr, exh, memh;
    int kind;
    logic [4:0] s1, s2, d;
    s1 = if_instr[19:15];
    s2 = if_instr[24:20];
    d  = if_instr[11:7];
    classify(if_instr[6:0], legal, u1, u2, wr, kind);
    exh  = hit(u1, s1, ex_wen, ex_rd) || hit(u2, s2, ex_wen, ex_rd);
    memh = hit(u1, s1, mem_wen, mem_rd) || hit(u2, s2, mem_wen, mem_rd);
`ifdef ID_MEM_FWD_EN
    st = if_valid && ex_is_load && exh;
`else
    st = if_valid && (exh || memh);
`endif
    nx = exp_q;
    if (!rst_n) nx = '0;
    else if (pipeline_en) begin
      if (flush || st) nx = '0;
      else begin
        nx.valid = if_valid;
        nx.pc    = if_pc;
        nx.op1   = operand(u1, s1, reg1);
        nx.op2   = operand(u2, s2, reg2);
        nx.imm   = model_imm(if_instr, kind);
        nx.rd    = d;
        nx.ill   = !legal || (u1 && s1 > 15) || (u2 && s2 > 15) || (wr && d > 15);
        nx.wen   = if_valid && wr && d != 0 && !nx.ill;
        nx.opc   = if_instr[6:0];
        nx.f3    = if_instr[14:12];
        nx.f7    = if_instr[30];
      end
    end
  endtask

  // Inputs are set by the caller just after a posedge; checks comb outputs, then the registered bundle.
  task automatic cycle();
    logic st;
    exp_t nx;
    #1;
    model(st, nx);
    last_stall = stall;
    chk("stall", stall, st);
    chk("rs1", rs1, if_instr[19:15]);
    chk("rs2", rs2, if_instr[24:20]);
    @(posedge clk);
    #1;
    exp_q = nx;
    chk("valid", idex_valid, exp_q.valid);
    chk("pc", idex_pc, exp_q.pc);
    chk("op1", idex_op1, exp_q.op1);
    chk("op2", idex_op2, exp_q.op2);
    chk("imm", idex_imm, exp_q.imm);
    chk("rd", idex_rd, exp_q.rd);
    chk("wen", idex_wen, exp_q.wen);
    chk("opcode", idex_opcode, exp_q.opc);
    chk("funct3", idex_funct3, exp_q.f3);
    chk("funct7b5", idex_funct7b5, exp_q.f7);
    chk("illegal", idex_illegal, exp_q.ill);
  endtask

  task automatic idle();
    rst_n = 1; pipeline_en = 1; flush = 0; if_valid = 0;
    if_pc = 32'h0; if_instr = 32'h00000013;
    reg1 = 0; reg2 = 0;
    ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_result = 0;
    mem_rd = 0; mem_wen = 0; mem_result = 0;
    wb_rd = 0; wb_wen = 0; wb_wdata = 0;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [4:0] pick(input logic [31:0] ins);
    case ($urandom_range(0, 2))
      0: return ins[19:15];
      1: return ins[24:20];
      default: return 5'($urandom_range(0, 15));
    endcase
  endfunction

  logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
  logic [31:0] ins;

  initial begin
    idle(); rst_n = 0;
    cycle(); cycle();
    chk("rst_valid", idex_valid, 0); chk("rst_pc", idex_pc, 0); chk("rst_op1", idex_op1, 0);
    chk("rst_imm", idex_imm, 0); chk("rst_wen", idex_wen, 0); chk("rst_stall", stall, 0);

    // add x6,x5,x0 with addi x5 in EX
    idle(); if_valid = 1; if_pc = 32'h100; if_instr = 32'h00028333;
    reg1 = 32'hDEAD; ex_rd = 5; ex_wen = 1; ex_result = 32'h11;
    cycle();
`ifdef ID_MEM_FWD_EN
    chk("exfwd_op1", idex_op1, 32'h11); chk("exfwd_stall", last_stall, 0);
`else
    chk("exhaz_stall", last_stall, 1); chk("exhaz_bubble", idex_valid, 0);
`endif

    // load-use: lw x7 in EX, add x8,x7,x7 in ID
    idle(); if_valid = 1; if_pc = 32'h104; if_instr = 32'h00738433;
    ex_rd = 7; ex_wen = 1; ex_is_load = 1;
    cycle();
    chk("ldu_stall", last_stall, 1); chk("ldu_bubble", idex_valid, 0); chk("ldu_wen", idex_wen, 0);
    ex_wen = 0; ex_is_load = 0; mem_rd = 7; mem_wen = 1; mem_result = 32'h1234;
    cycle();
`ifdef ID_MEM_FWD_EN
    chk("ldu_op1", idex_op1, 32'h1234); chk("ldu_op2", idex_op2, 32'h1234);
`endif
    mem_wen = 0; wb_rd = 7; wb_wen = 1; wb_wdata = 32'h1234;
    cycle();
    chk("ldwb_op1", idex_op1, 32'h1234); chk("ldwb_valid", idex_valid, 1);

    // WB bypass: add x4,x3,x0
    idle(); if_valid = 1; if_instr = 32'h00018233; wb_wen = 1; wb_rd = 3; wb_wdata = 32'hCAFE;
    cycle();
    chk("wb_op1", idex_op1, 32'hCAFE);
    wb_rd = 0;
    cycle();
    chk("wb_rd0_op1", idex_op1, 32'h0);
    if_instr = 32'h00000233; reg1 = 32'h5555;
    cycle();
    chk("x0_op1", idex_op1, 32'h0);

    // flush during load-use
    idle(); if_valid = 1; if_instr = 32'h00738433; ex_rd = 7; ex_wen = 1; ex_is_load = 1; flush = 1;
    cycle();
    chk("flush_valid", idex_valid, 0);
    idle(); if_valid = 1; if_pc = 32'h200; if_instr = 32'h00500093;
    cycle();
    chk("post_flush_valid", idex_valid, 1); chk("post_flush_imm", idex_imm, 5);
    chk("post_flush_pc", idex_pc, 32'h200);

    // illegal rd x16, beq -4, lui
    if_instr = 32'h00208833;
    cycle();
    chk("ill_flag", idex_illegal, 1); chk("ill_wen", idex_wen, 0);
    if_instr = 32'hFE000EE3;
    cycle();
    chk("beq_imm", idex_imm, 32'hFFFFFFFC); chk("beq_wen", idex_wen, 0);
    if_instr = 32'h123450B7;
    cycle();
    chk("lui_imm", idex_imm, 32'h12345000); chk("lui_wen", idex_wen, 1);
    pipeline_en = 0; if_pc = 32'h999; if_instr = 32'h00500093;
    cycle();
    chk("hold_imm", idex_imm, 32'h12345000);

    for (int n = 0; n < 1500; n++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      pipeline_en = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      if_valid    = ($urandom_range(0, 4) != 0);
      if_pc       = $urandom;
      ins         = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 9)];
      ins[19:15]  = rnd_reg();
      ins[24:20]  = rnd_reg();
      ins[11:7]   = rnd_reg();
      if_instr    = ins;
      reg1 = $urandom; reg2 = $urandom;
      ex_rd  = pick(ins); ex_wen  = 1'($urandom_range(0, 1)); ex_is_load = 1'($urandom_range(0, 1));
      mem_rd = pick(ins); mem_wen = 1'($urandom_range(0, 1));
      wb_rd  = pick(ins); wb_wen  = 1'($urandom_range(0, 1));
      ex_result = $urandom; mem_result = $urandom; wb_wdata = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
